// File: rtl/mem_master_if.sv
// User-side request/response bundle for mem_master: a valid/ready request
// channel plus a registered done pulse and the last read result.
interface mem_master_if #(
    parameter int width      = 8,
    parameter int addr_width = 5
);
    // A request transfers on a rising edge where req_valid && req_ready; the
    // requester keeps req_* stable until that edge. done pulses once per
    // completed transfer, and rdata is valid from the read's done cycle onward.
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [addr_width-1:0] req_addr;
    logic [width-1:0]      req_wdata;
    logic                  done;
    logic [width-1:0]      rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, done, rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, done, rdata
    );
endinterface

// File: rtl/mem_master.sv
// Single-outstanding master for a synchronous memory on a shared tristate bus:
// writes take one bus cycle and reads take two (address, then capture).
module mem_master #(
    parameter int width      = 8,
    parameter int size       = 32,
    parameter int addr_width = $clog2(size)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_master_if.slave           usr,
    output logic                  wen,
    output logic                  ren,
    output logic [addr_width-1:0] Addr,
    inout  wire  [width-1:0]      Data,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR   = 2'd1;
    localparam logic [1:0] S_RD_A = 2'd2;
    localparam logic [1:0] S_RD_B = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [addr_width-1:0] addr_q,  addr_d;
    logic [width-1:0]      wdata_q, wdata_d;
    logic [width-1:0]      rdata_q, rdata_d;
    logic                  done_q,  done_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (usr.req_valid) begin
                    addr_d  = usr.req_addr;
                    wdata_d = usr.req_wdata;
                    state_d = usr.req_write ? S_WR : S_RD_A;
                end
            end
            S_WR: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_RD_A: begin
                state_d = S_RD_B;
            end
            S_RD_B: begin
                // Memory only drives Data after loading its buffer at the RD_A edge.
                rdata_d = Data;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    // Memory-side outputs decode from registered state only, so a reset
    // drops them at once and req_* never reaches the bus combinationally.
    assign wen  = (state_q == S_WR);
    assign ren  = (state_q == S_RD_A) || (state_q == S_RD_B);
    assign Addr = addr_q;
    assign Data = wen ? wdata_q : {width{1'bz}};

    assign usr.req_ready = (state_q == S_IDLE);
    assign usr.done      = done_q;
    assign usr.rdata     = rdata_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master paired with a behavioural synchronous memory
// on a pulled-up shared data bus.
module tb_mem_master;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD_A = 2'd2;
    localparam logic [1:0] ST_RD_B = 2'd3;
    localparam logic [7:0] BUS_IDLE = 8'hFF;

    logic       clk;
    logic       rst_n;
    logic       wen;
    logic       ren;
    logic [4:0] addr_bus;
    wire  [7:0] data_bus;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    mem_master_if #(.width(8), .addr_width(5)) usr_if ();

    mem_master #(.width(8), .size(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .usr       (usr_if),
        .wen       (wen),
        .ren       (ren),
        .Addr      (addr_bus),
        .Data      (data_bus),
        .dbg_state (dbg_state)
    );

    pullup (data_bus);

    // Memory: writes on wen, loads its output buffer on a read edge and
    // drives the bus only from that edge while ren=1 and wen=0.
    logic [7:0] mem [0:31] = '{default: 8'h00};
    logic [7:0] mem_buf = 8'h00;
    logic       mem_drive_q = 1'b0;

    always @(posedge clk) begin
        if (wen) mem[addr_bus] <= data_bus;
        mem_drive_q <= ren && !wen;
        if (ren && !wen) mem_buf <= mem[addr_bus];
    end

    assign data_bus = (mem_drive_q && ren && !wen) ? mem_buf : 8'bzzzzzzzz;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        usr_if.req_valid = 1'b1;
        usr_if.req_write = 1'b1;
        usr_if.req_addr  = a;
        usr_if.req_wdata = d;
        tick();
        check("wr_state", dbg_state, ST_WR);
        check("wr_wen", wen, 1'b1);
        check("wr_addr", addr_bus, a);
        check("wr_data", data_bus, d);
        usr_if.req_valid = 1'b0;
        tick();
        check("wr_done", usr_if.done, 1'b1);
        check("wr_mem", mem[a], d);
    endtask

    task automatic do_read(input logic [4:0] a, input logic [7:0] exp);
        usr_if.req_valid = 1'b1;
        usr_if.req_write = 1'b0;
        usr_if.req_addr  = a;
        tick();
        check("rd_a_state", dbg_state, ST_RD_A);
        check("rd_a_ren", ren, 1'b1);
        check("rd_a_bus_z", data_bus, BUS_IDLE);
        usr_if.req_valid = 1'b0;
        tick();
        check("rd_b_state", dbg_state, ST_RD_B);
        check("rd_b_bus", data_bus, exp);
        tick();
        check("rd_done", usr_if.done, 1'b1);
        check("rd_rdata", usr_if.rdata, exp);
    endtask

    // Invariants sampled mid-cycle while out of reset.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            check("wen_ren_excl", wen & ren, 1'b0);
            check("ready_vs_ports", usr_if.req_ready, !(wen | ren));
            check("data_known", $isunknown(data_bus), 1'b0);
            if (done_prev) check("done_width", usr_if.done, 1'b0);
            done_prev <= usr_if.done;
        end else begin
            done_prev <= 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n            = 1'b1;
        usr_if.req_valid = 1'b0;
        usr_if.req_write = 1'b0;
        usr_if.req_addr  = '0;
        usr_if.req_wdata = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_wen", wen, 1'b0);
        check("rst_ren", ren, 1'b0);
        check("rst_addr", addr_bus, 5'd0);
        check("rst_done", usr_if.done, 1'b0);
        check("rst_rdata", usr_if.rdata, 8'h00);
        check("rst_ready", usr_if.req_ready, 1'b1);
        check("rst_bus_z", data_bus, BUS_IDLE);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Write 0xA5 to 3, accepted at the first edge after reset release.
        do_write(5'd3, 8'hA5);
        check("wr1_ready", usr_if.req_ready, 1'b1);
        check("wr1_wen_low", wen, 1'b0);
        check("wr1_addr_hold", addr_bus, 5'd3);
        check("wr1_bus_z", data_bus, BUS_IDLE);
        tick();
        check("wr1_done_clear", usr_if.done, 1'b0);

        // Write 0x3C to 31 then read 31 with valid held across the done cycle.
        usr_if.req_valid = 1'b1;
        usr_if.req_write = 1'b1;
        usr_if.req_addr  = 5'd31;
        usr_if.req_wdata = 8'h3C;
        tick();
        check("b2b_wr_addr", addr_bus, 5'd31);
        check("b2b_wr_data", data_bus, 8'h3C);
        usr_if.req_write = 1'b0;
        tick();
        check("b2b_done", usr_if.done, 1'b1);
        check("b2b_ready", usr_if.req_ready, 1'b1);
        tick();
        check("b2b_rd_a_state", dbg_state, ST_RD_A);
        check("b2b_rd_a_ren", ren, 1'b1);
        check("b2b_rd_a_addr", addr_bus, 5'd31);
        check("b2b_rd_a_done", usr_if.done, 1'b0);
        usr_if.req_valid = 1'b0;
        tick();
        check("b2b_rd_b_ren", ren, 1'b1);
        check("b2b_rd_b_bus", data_bus, 8'h3C);
        tick();
        check("b2b_rd_done", usr_if.done, 1'b1);
        check("b2b_rdata", usr_if.rdata, 8'h3C);
        check("b2b_ren_low", ren, 1'b0);

        // Neighbouring words, then read the first one back.
        do_write(5'd7, 8'h11);
        do_write(5'd8, 8'h22);
        do_read(5'd7, 8'h11);
        check("rd7_bus_z_idle", data_bus, BUS_IDLE);

        // Address changes while a read is in flight are ignored until IDLE.
        usr_if.req_valid = 1'b1;
        usr_if.req_write = 1'b0;
        usr_if.req_addr  = 5'd7;
        tick();
        check("hold_rd_a_addr", addr_bus, 5'd7);
        usr_if.req_addr = 5'd8;
        tick();
        check("hold_rd_b_addr", addr_bus, 5'd7);
        check("hold_rd_b_state", dbg_state, ST_RD_B);
        tick();
        check("hold_done", usr_if.done, 1'b1);
        check("hold_rdata", usr_if.rdata, 8'h11);
        tick();
        check("hold_next_state", dbg_state, ST_RD_A);
        check("hold_next_addr", addr_bus, 5'd8);
        usr_if.req_valid = 1'b0;
        tick();
        tick();
        check("hold_next_rdata", usr_if.rdata, 8'h22);

        // Reset in the middle of RD_B aborts the read.
        usr_if.req_valid = 1'b1;
        usr_if.req_addr  = 5'd7;
        tick();
        usr_if.req_valid = 1'b0;
        tick();
        check("abort_pre_ren", ren, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ren", ren, 1'b0);
        check("abort_wen", wen, 1'b0);
        check("abort_done", usr_if.done, 1'b0);
        check("abort_rdata", usr_if.rdata, 8'h00);
        check("abort_state", dbg_state, ST_IDLE);
        check("abort_bus_z", data_bus, BUS_IDLE);
        #1 rst_n = 1'b1;
        tick();
        check("abort_no_done", usr_if.done, 1'b0);
        check("abort_rdata_hold", usr_if.rdata, 8'h00);
        do_read(5'd7, 8'h11);

        // Reset during WR suppresses the memory write.
        usr_if.req_valid = 1'b1;
        usr_if.req_write = 1'b1;
        usr_if.req_addr  = 5'd9;
        usr_if.req_wdata = 8'h77;
        tick();
        usr_if.req_valid = 1'b0;
        check("sup_wen", wen, 1'b1);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        check("sup_no_done", usr_if.done, 1'b0);
        check("sup_mem", mem[9], 8'h00);
        do_read(5'd3, 8'hA5);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001: Parameter width, default 8, data word width in bits.
REQ-002: Parameter size, default 32, number of words in the attached memory.
REQ-003: Parameter addr_width, default $clog2(size), address width in bits.
REQ-004: clk  input  1  sole clock; all state changes on rising edge.
REQ-005: rst_n  input  1  reset, asynchronous, active-low.
REQ-006: req_valid  input  1  user request present.
REQ-007: req_ready  output  1  block can accept a request this cycle.
REQ-008: req_write  input  1  1 = write, 0 = read; sampled with the request.
REQ-009: req_addr  input  addr_width  request word address.
REQ-010: req_wdata  input  width  write data.
REQ-011: done  output  1  one-cycle completion pulse, issued for reads and writes.
REQ-012: rdata  output  width  last read result; holds its value until the next read completes.
REQ-013: wen  output  1  memory write enable.
REQ-014: ren  output  1  memory read enable.
REQ-015: Addr  output  addr_width  memory address.
REQ-016: Data  inout  width  shared bidirectional memory data bus.

Function
REQ-017: The FSM SHALL have exactly four states: IDLE, WR, RD_A, RD_B.
REQ-018: req_ready SHALL be 1 only in IDLE.
REQ-019: In IDLE, req_valid=1 at a rising edge SHALL latch req_write, req_addr and req_wdata, then enter WR (write) or RD_A (read).
REQ-020: Request inputs SHALL be ignored outside IDLE; the requester holds them until accepted.
REQ-021: WR SHALL last 1 cycle with wen=1, ren=0, Addr=latched address, Data driven with latched wdata; it then enters IDLE.
REQ-022: RD_A SHALL last 1 cycle with ren=1, wen=0, Addr=latched address; it then enters RD_B.
REQ-023: RD_B SHALL last 1 cycle with ren=1, wen=0, Addr held; at the exiting edge the block captures Data into rdata, then enters IDLE.
REQ-024: The memory loads its output buffer at the RD_A edge and drives Data only while ren=1 and wen=0, so capture SHALL occur only at the RD_B edge.
REQ-025: In IDLE: wen=0, ren=0, Addr holds its last value.
REQ-026: wen and ren SHALL never both be 1.
REQ-027: Data SHALL be driven by this block only in WR; in every other state it SHALL be high-impedance ({width{1'bz}}).
REQ-028: wen, ren, Addr and the Data output enable SHALL decode only from registered state and latched fields; there SHALL be no combinational path from req_* to the memory-side ports.
REQ-029: done SHALL be registered and high for exactly one cycle after leaving WR or RD_B, which coincides with IDLE.
REQ-030: A new request SHALL be acceptable in the same cycle done is high (back-to-back operation).
REQ-031: Latency from the accept edge to done high SHALL be 1 cycle for writes and 2 cycles for reads.
REQ-032: Throughput SHALL be 1 write per 2 cycles and 1 read per 3 cycles.
REQ-033: Addresses SHALL pass through unmodified, with no range check.

Reset
REQ-034: On rst_n=0, immediately and regardless of clk, the block SHALL set: state=IDLE, wen=0, ren=0, Addr=0, Data=Z, done=0, rdata=0, latched fields=0.
REQ-035: Reset asserted in WR before the write edge SHALL suppress the write; in RD_A or RD_B it SHALL abort the read with no done pulse and rdata=0.
REQ-036: After rst_n deasserts, the first request SHALL be acceptable at the first rising edge.

Verification (bench pairs the block with the team's memory block, width=8, size=32)
REQ-037: Write 0xA5 to address 3 -> wen high exactly 1 cycle with Addr=3 and Data=0xA5, done 1 cycle later, memory word 3 = 0xA5.
REQ-038: Write 0x3C to address 31, then read address 31 back-to-back (request held high) -> ren high 2 cycles, rdata=0x3C when done, accept on the done cycle.
REQ-039: Read address 7 after writing 0x11 to 7 and 0x22 to 8 -> rdata=0x11; Data is Z in IDLE and during RD_A before the memory drives it; no bus contention (no X on Data) at any time.
REQ-040: Assert rst_n low mid-RD_B -> wen, ren and done go 0 asynchronously, rdata=0, no done pulse; the next read returns correct data.
REQ-041: Hold req_valid with changing req_addr during a read -> the in-flight Addr stays constant and the new address is accepted only at the next IDLE.
REQ-042: Assertion checks run across all scenarios: never wen and ren both high, done width always 1 cycle, req_ready equals (state==IDLE).
